spmm_row_feeder: RTL and testbench

SPMM_ROW_FEEDER -- requirements
Module: spmm_row_feeder

---
 rtl/spmm_pkg.sv | 24 ++
 rtl/spmm_row_packer.sv | 49 ++++
 rtl/spmm_row_feeder.sv | 151 +++++++++++++++
 tb/tb_spmm_row_feeder.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spmm_pkg.sv
// Shared SPMM widths, feeder FSM state encoding and packing-limit helper.
package spmm_pkg;
  localparam int SPMM_DATA_WIDTH       = 8;
  localparam int SPMM_DOT_PRODUCT_SIZE = 5;
  localparam int SPMM_ROW_IDX_WIDTH    = 8;
  localparam int SPMM_COL_IDX_WIDTH    = $clog2(SPMM_DOT_PRODUCT_SIZE);
  localparam int SPMM_NODE_INFO_WIDTH  = SPMM_COL_IDX_WIDTH + 1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_ISSUE   = 3'd2,
    ST_WAIT    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_OUTPUT  = 3'd5
  } feeder_state_e;

  // A row is capped by the slot count and by what node_info's count field can encode.
  function automatic int nnz_limit(input int dps);
    int cnt_max;
    cnt_max = (1 << $clog2(dps)) - 1;
    return (dps < cnt_max) ? dps : cnt_max;
  endfunction
endpackage

// File: rtl/spmm_row_packer.sv
// Slot counter and slice placement: the k-th packed entry of a row lands in slice DPS-1-k.
import spmm_pkg::*;

module spmm_row_packer #(
  parameter int DATA_WIDTH       = SPMM_DATA_WIDTH,
  parameter int DOT_PRODUCT_SIZE = SPMM_DOT_PRODUCT_SIZE,
  parameter int COL_IDX_WIDTH    = $clog2(DOT_PRODUCT_SIZE),
  parameter int CNT_WIDTH        = $clog2(DOT_PRODUCT_SIZE)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     clear_i,
  input  logic                                     push_i,
  input  logic [COL_IDX_WIDTH-1:0]                 col_i,
  input  logic [DATA_WIDTH-1:0]                    val_i,
  output logic                                     full_o,
  output logic [CNT_WIDTH-1:0]                     nnz_next_o,
  output logic [DOT_PRODUCT_SIZE*COL_IDX_WIDTH-1:0] col_idx_o,
  output logic [DOT_PRODUCT_SIZE*DATA_WIDTH-1:0]    value_o
);
  localparam int LIMIT = nnz_limit(DOT_PRODUCT_SIZE);

  logic [CNT_WIDTH-1:0]                     cnt_q;
  logic [DOT_PRODUCT_SIZE*COL_IDX_WIDTH-1:0] col_q;
  logic [DOT_PRODUCT_SIZE*DATA_WIDTH-1:0]    val_q;
  logic                                     take;

  assign full_o     = (cnt_q == CNT_WIDTH'(LIMIT));
  assign take       = push_i && !full_o;
  assign nnz_next_o = cnt_q + CNT_WIDTH'(take);
  assign col_idx_o  = col_q;
  assign value_o    = val_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      cnt_q <= '0;
      col_q <= '0;
      val_q <= '0;
    end else if (take) begin
      cnt_q <= cnt_q + CNT_WIDTH'(1);
      for (int s = 0; s < DOT_PRODUCT_SIZE; s++) begin
        if (cnt_q == CNT_WIDTH'(DOT_PRODUCT_SIZE - 1 - s)) begin
          col_q[s*COL_IDX_WIDTH +: COL_IDX_WIDTH] <= col_i;
          val_q[s*DATA_WIDTH +: DATA_WIDTH]       <= val_i;
        end
      end
    end
  end
endmodule

// File: rtl/spmm_row_feeder.sv
// Packs one sparse feature row into a PE packet, waits for the PE result and streams it out.
//   state   | meaning
//   IDLE    | ready for a new row, weights loadable
//   COLLECT | packing entries until feat_last_i
//   ISSUE   | pe_valid_o high for one cycle
//   WAIT    | holding packet until pe_ready_i
//   CAPTURE | registering result_i
//   OUTPUT  | presenting result until res_ready_i
import spmm_pkg::*;

module spmm_row_feeder #(
  parameter  int DATA_WIDTH       = SPMM_DATA_WIDTH,
  parameter  int DOT_PRODUCT_SIZE = SPMM_DOT_PRODUCT_SIZE,
  parameter  int ROW_IDX_WIDTH    = SPMM_ROW_IDX_WIDTH,
  localparam int COL_IDX_WIDTH    = $clog2(DOT_PRODUCT_SIZE),
  localparam int NODE_INFO_WIDTH  = $clog2(DOT_PRODUCT_SIZE) + 1
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic                                      feat_valid_i,
  input  logic [COL_IDX_WIDTH-1:0]                  feat_col_idx_i,
  input  logic [DATA_WIDTH-1:0]                     feat_value_i,
  input  logic                                      feat_last_i,
  input  logic                                      feat_null_i,
  output logic                                      feat_ready_o,
  input  logic                                      wgt_valid_i,
  input  logic [DOT_PRODUCT_SIZE*DATA_WIDTH-1:0]    wgt_i,
  output logic                                      pe_valid_o,
  output logic [DOT_PRODUCT_SIZE*COL_IDX_WIDTH-1:0] col_idx_o,
  output logic [DOT_PRODUCT_SIZE*DATA_WIDTH-1:0]    value_o,
  output logic [NODE_INFO_WIDTH-1:0]                node_info_o,
  output logic [DOT_PRODUCT_SIZE*DATA_WIDTH-1:0]    weight_o,
  input  logic                                      pe_ready_i,
  input  logic [DATA_WIDTH-1:0]                     result_i,
  output logic                                      res_valid_o,
  output logic [DATA_WIDTH-1:0]                     res_data_o,
  output logic [ROW_IDX_WIDTH-1:0]                  res_row_o,
  input  logic                                      res_ready_i,
  output logic                                      err_o
);
  feeder_state_e                         state_q;
  logic                                  feat_ready_q, pe_valid_q, res_valid_q, err_q;
  logic [DATA_WIDTH-1:0]                 res_data_q;
  logic [ROW_IDX_WIDTH-1:0]              row_q;
  logic [NODE_INFO_WIDTH-1:0]            node_info_q;
  logic [DOT_PRODUCT_SIZE*DATA_WIDTH-1:0] weight_q;

  logic                       accept, push, pk_full, pk_clear;
  logic [NODE_INFO_WIDTH-2:0] pk_nnz_next;

  assign accept   = feat_valid_i && feat_ready_q;
  assign push     = accept && !feat_null_i;
  assign pk_clear = (state_q == ST_OUTPUT) && res_ready_i;

  spmm_row_packer #(
    .DATA_WIDTH      (DATA_WIDTH),
    .DOT_PRODUCT_SIZE(DOT_PRODUCT_SIZE),
    .COL_IDX_WIDTH   (COL_IDX_WIDTH),
    .CNT_WIDTH       (NODE_INFO_WIDTH - 1)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear_i   (pk_clear),
    .push_i    (push),
    .col_i     (feat_col_idx_i),
    .val_i     (feat_value_i),
    .full_o    (pk_full),
    .nnz_next_o(pk_nnz_next),
    .col_idx_o (col_idx_o),
    .value_o   (value_o)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      feat_ready_q <= 1'b1;
      pe_valid_q   <= 1'b0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      row_q        <= '0;
      err_q        <= 1'b0;
      node_info_q  <= '0;
      weight_q     <= '0;
    end else begin
      pe_valid_q <= 1'b0;
      if (push && pk_full) err_q <= 1'b1;
      case (state_q)
        ST_IDLE: begin
          if (wgt_valid_i) weight_q <= wgt_i;
          if (accept) begin
            if (feat_null_i) begin
              // Empty row: skip the PE entirely and report a zero result.
              if (feat_last_i) begin
                res_data_q   <= '0;
                res_valid_q  <= 1'b1;
                feat_ready_q <= 1'b0;
                state_q      <= ST_OUTPUT;
              end
            end else if (feat_last_i) begin
              pe_valid_q   <= 1'b1;
              node_info_q  <= {pk_nnz_next, 1'b1};
              feat_ready_q <= 1'b0;
              state_q      <= ST_ISSUE;
            end else begin
              state_q <= ST_COLLECT;
            end
          end
        end
        ST_COLLECT: begin
          if (accept && feat_last_i) begin
            pe_valid_q   <= 1'b1;
            node_info_q  <= {pk_nnz_next, 1'b1};
            feat_ready_q <= 1'b0;
            state_q      <= ST_ISSUE;
          end
        end
        ST_ISSUE: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (pe_ready_i) state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          res_data_q  <= result_i;
          res_valid_q <= 1'b1;
          state_q     <= ST_OUTPUT;
        end
        ST_OUTPUT: begin
          if (res_ready_i) begin
            res_valid_q  <= 1'b0;
            row_q        <= row_q + ROW_IDX_WIDTH'(1);
            node_info_q  <= '0;
            feat_ready_q <= 1'b1;
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          feat_ready_q <= 1'b1;
          state_q      <= ST_IDLE;
        end
      endcase
    end
  end

  assign feat_ready_o = feat_ready_q;
  assign pe_valid_o   = pe_valid_q;
  assign node_info_o  = node_info_q;
  assign weight_o     = weight_q;
  assign res_valid_o  = res_valid_q;
  assign res_data_o   = res_data_q;
  assign res_row_o    = row_q;
  assign err_o        = err_q;
endmodule

// File: tb/tb_spmm_row_feeder.sv
// Directed bench for spmm_row_feeder: PE responder, row-level reference model and per-cycle compare.
module tb_spmm_row_feeder;
  localparam int DW  = 8;
  localparam int DPS = 5;
  localparam int RW  = 8;
  localparam int CW  = 3;
  localparam int NIW = 4;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              feat_valid_i = 1'b0;
  logic [CW-1:0]     feat_col_idx_i = '0;
  logic [DW-1:0]     feat_value_i = '0;
  logic              feat_last_i = 1'b0;
  logic              feat_null_i = 1'b0;
  logic              feat_ready_o;
  logic              wgt_valid_i = 1'b0;
  logic [DPS*DW-1:0] wgt_i = '0;
  logic              pe_valid_o;
  logic [DPS*CW-1:0] col_idx_o;
  logic [DPS*DW-1:0] value_o;
  logic [NIW-1:0]    node_info_o;
  logic [DPS*DW-1:0] weight_o;
  logic              pe_ready_i;
  logic [DW-1:0]     result_i = '0;
  logic              res_valid_o;
  logic [DW-1:0]     res_data_o;
  logic [RW-1:0]     res_row_o;
  logic              res_ready_i = 1'b1;
  logic              err_o;

  logic pe_ready_auto = 1'b0;
  logic pe_force = 1'b0;
  assign pe_ready_i = pe_ready_auto | pe_force;

  always #5 clk = ~clk;

  spmm_row_feeder dut (
    .clk(clk), .rst_n(rst_n),
    .feat_valid_i(feat_valid_i), .feat_col_idx_i(feat_col_idx_i), .feat_value_i(feat_value_i),
    .feat_last_i(feat_last_i), .feat_null_i(feat_null_i), .feat_ready_o(feat_ready_o),
    .wgt_valid_i(wgt_valid_i), .wgt_i(wgt_i),
    .pe_valid_o(pe_valid_o), .col_idx_o(col_idx_o), .value_o(value_o), .node_info_o(node_info_o),
    .weight_o(weight_o), .pe_ready_i(pe_ready_i), .result_i(result_i),
    .res_valid_o(res_valid_o), .res_data_o(res_data_o), .res_row_o(res_row_o),
    .res_ready_i(res_ready_i), .err_o(err_o)
  );

  int checks = 0;
  int passed = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Reference model state
  int          w_model[DPS];
  int          exp_row = 0;
  bit          exp_err = 1'b0;
  int          row_c[8];
  int          row_v[8];
  logic [63:0] q_ni[$], q_col[$], q_val[$];
  logic [63:0] q_data[$], q_row[$], q_err[$];

  int          pe_pulses = 0;
  int          res_count = 0;
  logic [63:0] last_ni = '0, last_data = '0, last_row = '0;

  // PE responder
  int          pe_delay = 0;
  bit          pe_auto = 1'b1;
  logic [DW-1:0] pe_sum;

  always begin
    @(negedge clk);
    if (pe_auto && rst_n && pe_valid_o) begin
      pe_sum = '0;
      for (int i = 0; i < DPS; i++) begin
        int c;
        c = int'(col_idx_o[i*CW +: CW]);
        if (c < DPS) pe_sum = pe_sum + DW'(value_o[i*DW +: DW] * weight_o[c*DW +: DW]);
      end
      repeat (pe_delay + 1) @(negedge clk);
      pe_ready_auto = 1'b1;
      result_i = pe_sum;
      @(negedge clk);
      pe_ready_auto = 1'b0;
    end
  end

  // Compare process
  always @(negedge clk) begin
    if (rst_n) begin
      if (pe_valid_o) begin
        pe_pulses++;
        last_ni = 64'(node_info_o);
        if (q_ni.size() == 0) chk("pe_unexpected", 64'(pe_valid_o), 64'(0));
        else begin
          chk("node_info", 64'(node_info_o), q_ni.pop_front());
          chk("col_idx", 64'(col_idx_o), q_col.pop_front());
          chk("value", 64'(value_o), q_val.pop_front());
        end
      end
      if (res_valid_o) begin
        if (q_data.size() == 0) chk("res_unexpected", 64'(res_valid_o), 64'(0));
        else begin
          chk("res_data", 64'(res_data_o), q_data[0]);
          chk("res_row", 64'(res_row_o), q_row[0]);
          chk("err", 64'(err_o), q_err[0]);
          if (res_ready_i) begin
            last_data = 64'(res_data_o);
            last_row  = 64'(res_row_o);
            void'(q_data.pop_front());
            void'(q_row.pop_front());
            void'(q_err.pop_front());
            res_count++;
          end
        end
      end
    end
  end

  task automatic wait_ready();
    int t = 0;
    @(negedge clk);
    while (!feat_ready_o && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("feat_ready_timeout", 64'(feat_ready_o), 64'(1));
  endtask

  task automatic send_row(input int n, input bit nul);
    logic [63:0] ecol, evl;
    int sum, nnz;
    if (nul) begin
      q_data.push_back(64'(0));
    end else begin
      nnz  = (n < DPS) ? n : DPS;
      ecol = '0;
      evl  = '0;
      sum  = 0;
      for (int k = 0; k < nnz; k++) begin
        ecol[(DPS-1-k)*CW +: CW] = CW'(row_c[k]);
        evl[(DPS-1-k)*DW +: DW]  = DW'(row_v[k]);
        sum += row_v[k] * w_model[row_c[k]];
      end
      if (n > DPS) exp_err = 1'b1;
      q_ni.push_back(64'((nnz << 1) | 1));
      q_col.push_back(ecol);
      q_val.push_back(evl);
      q_data.push_back(64'(sum % 256));
    end
    q_row.push_back(64'(exp_row));
    q_err.push_back(64'(exp_err));
    exp_row = (exp_row + 1) % 256;
    for (int k = 0; k < (nul ? 1 : n); k++) begin
      feat_valid_i   = 1'b1;
      feat_col_idx_i = nul ? '0 : CW'(row_c[k]);
      feat_value_i   = nul ? '0 : DW'(row_v[k]);
      feat_last_i    = nul || (k == n - 1);
      feat_null_i    = nul;
      wait_ready();
      @(posedge clk); #1;
    end
    feat_valid_i = 1'b0;
    feat_last_i  = 1'b0;
    feat_null_i  = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (q_data.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) chk("drain_timeout", 64'(q_data.size()), 64'(0));
    @(posedge clk); #1;
  endtask

  task automatic load_w(input logic [DPS*DW-1:0] w);
    drain();
    wgt_valid_i = 1'b1;
    wgt_i       = w;
    @(posedge clk); #1;
    wgt_valid_i = 1'b0;
    for (int i = 0; i < DPS; i++) w_model[i] = int'(w[i*DW +: DW]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d", passed, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int p0, r0, t;
    for (int i = 0; i < DPS; i++) w_model[i] = 0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_feat_ready", 64'(feat_ready_o), 64'(1));
    chk("rst_pe_valid", 64'(pe_valid_o), 64'(0));
    chk("rst_res_valid", 64'(res_valid_o), 64'(0));
    chk("rst_res_data", 64'(res_data_o), 64'(0));
    chk("rst_res_row", 64'(res_row_o), 64'(0));
    chk("rst_err", 64'(err_o), 64'(0));
    chk("rst_col_idx", 64'(col_idx_o), 64'(0));
    chk("rst_value", 64'(value_o), 64'(0));
    chk("rst_node_info", 64'(node_info_o), 64'(0));
    chk("rst_weight", 64'(weight_o), 64'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Three-entry row, unit weights
    load_w(40'h0101010101);
    row_c[0] = 2; row_v[0] = 3;
    row_c[1] = 0; row_v[1] = 4;
    row_c[2] = 4; row_v[2] = 1;
    send_row(3, 1'b0);
    drain();
    chk("r025_node_info", last_ni, 64'(7));
    chk("r025_res_data", last_data, 64'(8));
    chk("r025_res_row", last_row, 64'(0));
    chk("r025_pe_pulses", 64'(pe_pulses), 64'(1));

    // Null row bypasses the PE
    p0 = pe_pulses;
    send_row(1, 1'b1);
    drain();
    chk("null_no_pe", 64'(pe_pulses), 64'(p0));
    chk("null_res_data", last_data, 64'(0));
    chk("null_res_row", last_row, 64'(1));

    // Distinct weights; a weight load during ISSUE/WAIT must be ignored
    load_w({8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    pe_delay = 5;
    row_c[0] = 1; row_v[0] = 2;
    row_c[1] = 3; row_v[1] = 5;
    send_row(2, 1'b0);
    wgt_valid_i = 1'b1;
    wgt_i       = '0;
    repeat (2) begin @(posedge clk); #1; end
    wgt_valid_i = 1'b0;
    drain();
    chk("wgt_ignored_res", last_data, 64'(24));
    chk("wgt_ignored_reg", 64'(weight_o), 64'h0504030201);

    // Result backpressure for 10 cycles
    pe_delay    = 0;
    res_ready_i = 1'b0;
    row_c[0] = 4; row_v[0] = 7;
    row_c[1] = 2; row_v[1] = 9;
    send_row(2, 1'b0);
    t = 0;
    @(negedge clk);
    while (!res_valid_o && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("res_valid_timeout", 64'(res_valid_o), 64'(1));
    repeat (10) begin
      @(negedge clk);
      chk("bp_res_valid", 64'(res_valid_o), 64'(1));
      chk("bp_res_data", 64'(res_data_o), 64'(62));
      chk("bp_feat_ready", 64'(feat_ready_o), 64'(0));
    end
    @(posedge clk); #1;
    res_ready_i = 1'b1;
    drain();
    chk("bp_res_row", last_row, 64'(3));

    // Six entries: sixth dropped, sticky error
    for (int k = 0; k < 6; k++) begin
      row_c[k] = k % 5;
      row_v[k] = (k == 5) ? 9 : 1;
    end
    send_row(6, 1'b0);
    drain();
    chk("ovf_node_info", last_ni, 64'(11));
    chk("ovf_res_data", last_data, 64'(15));
    chk("ovf_err", 64'(err_o), 64'(1));
    row_c[0] = 0; row_v[0] = 6;
    send_row(1, 1'b0);
    drain();
    chk("ovf_err_sticky", 64'(err_o), 64'(1));
    chk("ovf_next_res", last_data, 64'(6));

    // Reset during WAIT, then a stale pe_ready pulse
    pe_auto = 1'b0;
    row_c[0] = 1; row_v[0] = 1;
    row_c[1] = 2; row_v[1] = 2;
    send_row(2, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    q_data.delete(); q_row.delete(); q_err.delete();
    q_ni.delete(); q_col.delete(); q_val.delete();
    exp_row = 0;
    exp_err = 1'b0;
    for (int i = 0; i < DPS; i++) w_model[i] = 0;
    r0 = res_count;
    pe_force = 1'b1;
    @(posedge clk); #1;
    pe_force = 1'b0;
    repeat (8) @(negedge clk);
    chk("rstw_no_res", 64'(res_count), 64'(r0));
    chk("rstw_res_valid", 64'(res_valid_o), 64'(0));
    chk("rstw_feat_ready", 64'(feat_ready_o), 64'(1));
    chk("rstw_err", 64'(err_o), 64'(0));
    chk("rstw_weight", 64'(weight_o), 64'(0));
    chk("rstw_col_idx", 64'(col_idx_o), 64'(0));
    chk("rstw_node_info", 64'(node_info_o), 64'(0));
    @(posedge clk); #1;
    pe_auto = 1'b1;

    // 257 back-to-back rows: row index wraps 255 -> 0
    load_w({8'd5, 8'd4, 8'd3, 8'd2, 8'd1});
    r0 = res_count;
    for (int i = 0; i < 257; i++) begin
      row_c[0] = i % 5;
      row_v[0] = (i % 7) + 1;
      send_row(1, 1'b0);
    end
    drain();
    chk("wrap_rows", 64'(res_count - r0), 64'(257));
    chk("wrap_last_row", last_row, 64'(0));
    chk("queues_empty", 64'(q_data.size() + q_ni.size()), 64'(0));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
